// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the receive-side CRC frame checker.
package crc_pkg;

   localparam int CRC_WIDTH     = 16;
   localparam logic [CRC_WIDTH-1:0] CRC_POLY_DEF = 16'h8005;
   localparam logic [CRC_WIDTH-1:0] CRC_INIT_DEF = 16'h0000;
   localparam int PAYLOAD_BITS  = 112;
   localparam int FRAME_BYTES   = 16;
   localparam int PAYLOAD_BYTES = PAYLOAD_BITS / 8;
   localparam int FRAME_BITS    = FRAME_BYTES * 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/crc_frame_checker_if.sv
// Byte stream from the UART receiver into the frame checker.
//
// Handshake: the source holds rx_data stable while rx_valid is high; a byte
// moves only in a cycle where rx_valid and rx_ready are both high at the
// rising clock edge. rx_ready does not depend on rx_valid. A byte offered
// while rx_ready is low is not stored and counts as an overrun.
interface crc_frame_checker_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );

endinterface

// File: rtl/crc16_serial_lfsr.sv
// Bit-serial CRC-16 register: one message bit per enabled cycle, MSB first.
module crc16_serial_lfsr
   import crc_pkg::*;
#(
   parameter logic [CRC_WIDTH-1:0] POLY = CRC_POLY_DEF,
   parameter logic [CRC_WIDTH-1:0] INIT = CRC_INIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 din,
   output logic [CRC_WIDTH-1:0] crc
);

   logic [CRC_WIDTH-1:0] crc_q;
   logic                 fb;

   assign fb  = crc_q[CRC_WIDTH-1] ^ din;
   assign crc = crc_q;

   // Clear has priority over a shift so an abort on the last bit still restarts cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= INIT;
      end else if (clr) begin
         crc_q <= INIT;
      end else if (en) begin
         crc_q <= {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
   end

endmodule

// File: rtl/crc_frame_checker.sv
// Collects a 16-byte frame (14 payload + 2 CRC bytes), recomputes the CRC
// bit-serially over the payload and reports the payload with a verdict.
module crc_frame_checker
   import crc_pkg::*;
#(
   parameter int unsigned          TIMEOUT_CYCLES = 100000,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY       = CRC_POLY_DEF,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT       = CRC_INIT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   crc_frame_checker_if.slave      rx,
   output logic [PAYLOAD_BITS-1:0] data_out,
   output logic [CRC_WIDTH-1:0]    crc_rx,
   output logic [CRC_WIDTH-1:0]    crc_calc,
   output logic                    frame_valid,
   output logic                    crc_ok,
   output logic                    frame_abort,
   output state_t                  dbg_state_o
);

   localparam int CNT_W = $clog2(FRAME_BYTES + 1);
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [7:0]              sreg_q, sreg_d;
   logic                    ovr_q, ovr_d;
   logic [FRAME_BITS-1:0]   frame_q;

   logic [PAYLOAD_BITS-1:0] data_out_q;
   logic [CRC_WIDTH-1:0]    crc_rx_q;
   logic [CRC_WIDTH-1:0]    crc_calc_q;
   logic                    crc_ok_q;

   logic                    rx_ready_c;
   logic                    accept_c;
   logic                    ovr_now_c;
   logic                    lfsr_clr_c;
   logic                    lfsr_en_c;
   logic                    lfsr_din_c;
   logic                    frame_valid_c;
   logic                    frame_abort_c;
   logic                    commit_c;
   logic [CRC_WIDTH-1:0]    lfsr_crc;

   crc16_serial_lfsr #(
      .POLY (CRC_POLY),
      .INIT (CRC_INIT)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lfsr_clr_c),
      .en    (lfsr_en_c),
      .din   (lfsr_din_c),
      .crc   (lfsr_crc)
   );

   // FSM state and per-frame counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         gap_q      <= '0;
         sreg_q     <= '0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_q      <= gap_d;
         sreg_q     <= sreg_d;
         ovr_q      <= ovr_d;
      end
   end

   // Next state, handshake, LFSR control and the one-cycle result pulses.
   // A byte offered during DONE suppresses the result, so the DONE pulses
   // and the output bypass depend on rx_valid in that same cycle.
   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      gap_d         = gap_q;
      sreg_d        = sreg_q;
      ovr_d         = ovr_q;
      rx_ready_c    = 1'b0;
      accept_c      = 1'b0;
      ovr_now_c     = 1'b0;
      lfsr_clr_c    = 1'b0;
      lfsr_en_c     = 1'b0;
      lfsr_din_c    = sreg_q[7];
      frame_valid_c = 1'b0;
      frame_abort_c = 1'b0;
      commit_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            rx_ready_c = 1'b1;
            gap_d      = '0;
            if (rx.rx_valid) begin
               accept_c  = 1'b1;
               sreg_d    = rx.rx_data;
               bit_cnt_d = '0;
               ovr_d     = 1'b0;
               state_d   = ST_SHIFT;
            end
         end

         ST_COLLECT: begin
            rx_ready_c = 1'b1;
            if (rx.rx_valid) begin
               accept_c  = 1'b1;
               sreg_d    = rx.rx_data;
               bit_cnt_d = '0;
               ovr_d     = 1'b0;
               gap_d     = '0;
               state_d   = ST_SHIFT;
            end else if (gap_q == GAP_LIMIT) begin
               frame_abort_c = 1'b1;
               lfsr_clr_c    = 1'b1;
               byte_cnt_d    = '0;
               gap_d         = '0;
               state_d       = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         ST_SHIFT: begin
            // The two CRC bytes pass through SHIFT only to keep frame timing uniform.
            lfsr_en_c = (byte_cnt_q < CNT_W'(PAYLOAD_BYTES));
            sreg_d    = {sreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            ovr_now_c = ovr_q | rx.rx_valid;
            ovr_d     = ovr_now_c;
            if (bit_cnt_q == 3'd7) begin
               if (ovr_now_c) begin
                  frame_abort_c = 1'b1;
                  lfsr_clr_c    = 1'b1;
                  byte_cnt_d    = '0;
                  ovr_d         = 1'b0;
                  state_d       = ST_IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  state_d    = (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) ? ST_DONE : ST_COLLECT;
               end
            end
         end

         ST_DONE: begin
            lfsr_clr_c = 1'b1;
            byte_cnt_d = '0;
            ovr_d      = 1'b0;
            state_d    = ST_IDLE;
            if (rx.rx_valid) begin
               frame_abort_c = 1'b1;
            end else begin
               frame_valid_c = 1'b1;
               commit_c      = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Byte k of the frame lands at a fixed slot, byte 0 in the top bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
      end else begin
         for (int k = 0; k < FRAME_BYTES; k++) begin
            if (accept_c && (byte_cnt_q == CNT_W'(k))) begin
               frame_q[FRAME_BITS-1-8*k -: 8] <= rx.rx_data;
            end
         end
      end
   end

   // Result registers hold the last committed frame until the next good DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
         crc_rx_q   <= '0;
         crc_calc_q <= '0;
         crc_ok_q   <= 1'b0;
      end else if (commit_c) begin
         data_out_q <= frame_q[FRAME_BITS-1 -: PAYLOAD_BITS];
         crc_rx_q   <= frame_q[CRC_WIDTH-1:0];
         crc_calc_q <= lfsr_crc;
         crc_ok_q   <= (frame_q[CRC_WIDTH-1:0] == lfsr_crc);
      end
   end

   // During the committing DONE cycle the new values are shown alongside frame_valid.
   assign data_out    = commit_c ? frame_q[FRAME_BITS-1 -: PAYLOAD_BITS] : data_out_q;
   assign crc_rx      = commit_c ? frame_q[CRC_WIDTH-1:0] : crc_rx_q;
   assign crc_calc    = commit_c ? lfsr_crc : crc_calc_q;
   assign crc_ok      = commit_c ? (frame_q[CRC_WIDTH-1:0] == lfsr_crc) : crc_ok_q;
   assign frame_valid = frame_valid_c;
   assign frame_abort = frame_abort_c;
   assign rx.rx_ready = rx_ready_c;
   assign dbg_state_o = state_q;

endmodule
